// File: rtl/div_pkg.sv
// Shared widths, handshake levels and FSM encodings for the EX-stage divider.
package div_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // Number of restoring-division iterations, one quotient bit per step.
    localparam logic [5:0] DivSteps = 6'd32;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Two's-complement negate of a register-width value.
    function automatic logic [RegBus-1:0] neg32(input logic [RegBus-1:0] v);
        return ~v + RegBus'(1);
    endfunction

endpackage

// File: rtl/div_if.sv
// EX-stage <-> divider request/response bundle.
interface div_if;
    import div_pkg::*;

    logic                    signed_div_i;
    logic [RegBus-1:0]       opdata1_i;
    logic [RegBus-1:0]       opdata2_i;
    logic                    start_i;
    logic                    annul_i;
    logic [DoubleRegBus-1:0] result_o;
    logic                    ready_o;

    // EX stage drives the request and consumes the result.
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    // Divider side.
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div.sv
// Bit-serial restoring 32-bit divider (DIV/DIVU): 32 iterations, then a
// sign fix-up cycle. Result is {remainder, quotient}, held until EX drops start.
module div
    import div_pkg::*;
(
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);

    div_state_e              state_reg, state_next;
    logic [5:0]              cnt_reg, cnt_next;
    logic [64:0]             work_reg, work_next;
    logic [RegBus-1:0]       divisor_reg, divisor_next;
    logic                    signed_reg, signed_next;
    logic                    sign1_reg, sign1_next;
    logic                    sign2_reg, sign2_next;
    logic [DoubleRegBus-1:0] result_reg, result_next;
    logic                    ready_reg, ready_next;

    logic [RegBus:0]         diff;
    logic [RegBus-1:0]       abs1, abs2;
    logic [RegBus-1:0]       quot_fix, rem_fix;

    // Datapath terms: trial subtraction, operand magnitudes, final sign fix-up.
    always_comb begin
        diff = {1'b0, work_reg[63:32]} - {1'b0, divisor_reg};
        abs1 = (bus.signed_div_i && bus.opdata1_i[RegBus-1]) ? neg32(bus.opdata1_i) : bus.opdata1_i;
        abs2 = (bus.signed_div_i && bus.opdata2_i[RegBus-1]) ? neg32(bus.opdata2_i) : bus.opdata2_i;
        // Quotient is negative when operand signs differ; remainder follows the dividend.
        quot_fix = (signed_reg && (sign1_reg != sign2_reg)) ? neg32(work_reg[31:0]) : work_reg[31:0];
        rem_fix  = (signed_reg && sign1_reg) ? neg32(work_reg[64:33]) : work_reg[64:33];
    end

    // Next-state and next-output logic for the divider FSM.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        work_next    = work_reg;
        divisor_next = divisor_reg;
        signed_next  = signed_reg;
        sign1_next   = sign1_reg;
        sign2_next   = sign2_reg;
        result_next  = result_reg;
        ready_next   = ready_reg;

        unique case (state_reg)
            DivFree: begin
                result_next = '0;
                ready_next  = DivResultNotReady;
                if (bus.start_i == DivStart && !bus.annul_i) begin
                    signed_next = bus.signed_div_i;
                    sign1_next  = bus.opdata1_i[RegBus-1];
                    sign2_next  = bus.opdata2_i[RegBus-1];
                    if (bus.opdata2_i == '0) begin
                        state_next = DivByZero;
                    end else begin
                        state_next   = DivOn;
                        cnt_next     = '0;
                        // Pre-shifted by one so the first compare sees the dividend MSB.
                        work_next    = {32'b0, abs1, 1'b0};
                        divisor_next = abs2;
                    end
                end
            end

            DivByZero: begin
                if (bus.annul_i) begin
                    state_next  = DivFree;
                    result_next = '0;
                    ready_next  = DivResultNotReady;
                end else begin
                    // HI/LO are architecturally unpredictable here; report zero.
                    state_next  = DivEnd;
                    result_next = '0;
                    ready_next  = DivResultReady;
                end
            end

            DivOn: begin
                if (bus.annul_i) begin
                    state_next  = DivFree;
                    result_next = '0;
                    ready_next  = DivResultNotReady;
                end else if (cnt_reg != DivSteps) begin
                    // Borrow means the divisor did not fit: shift in a 0 bit.
                    if (diff[RegBus]) begin
                        work_next = {work_reg[63:0], 1'b0};
                    end else begin
                        work_next = {diff[31:0], work_reg[31:0], 1'b1};
                    end
                    cnt_next = cnt_reg + 6'd1;
                end else begin
                    state_next  = DivEnd;
                    result_next = {rem_fix, quot_fix};
                    ready_next  = DivResultReady;
                end
            end

            DivEnd: begin
                // Annul is ignored: the result has already been produced.
                if (bus.start_i == DivStop) begin
                    state_next  = DivFree;
                    result_next = '0;
                    ready_next  = DivResultNotReady;
                end
            end

            default: begin
                state_next = DivFree;
            end
        endcase
    end

    // State and datapath registers; reset returns everything to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= DivFree;
            cnt_reg     <= '0;
            work_reg    <= '0;
            divisor_reg <= '0;
            signed_reg  <= 1'b0;
            sign1_reg   <= 1'b0;
            sign2_reg   <= 1'b0;
            result_reg  <= '0;
            ready_reg   <= DivResultNotReady;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            work_reg    <= work_next;
            divisor_reg <= divisor_next;
            signed_reg  <= signed_next;
            sign1_reg   <= sign1_next;
            sign2_reg   <= sign2_next;
            result_reg  <= result_next;
            ready_reg   <= ready_next;
        end
    end

    assign bus.result_o = result_reg;
    assign bus.ready_o  = ready_reg;

endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit integer divider for the EX stage, serving DIV/DIVU. The EX stage launches an operation and holds its stall request until `ready_o` rises. The EX stage then forwards the 64-bit result as `ex_hi`/`ex_lo` with `ex_whilo` asserted to the EX/MEM pipeline register. Operation is bit-serial restoring division: 32 iterations plus sign fix-up.

## Interface
- No parameters; widths come from shared defines (`RegBus` = 32, `DoubleRegBus` = 64).
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, synchronous, active-high (`RstEnable`).
- `signed_div_i` in 1: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start_i`.
- `opdata1_i` in 32: dividend; sampled at launch.
- `opdata2_i` in 32: divisor; sampled at launch.
- `start_i` in 1: request. Held high by EX until it consumes the result.
- `annul_i` in 1: abort; cancels any operation in flight (exception/flush).
- `result_o` out 64: {remainder[63:32], quotient[31:0]}; registered.
- `ready_o` out 1: result valid (`DivResultReady`); registered.

## Operation
- FSM states (shared encodings): `DivFree`, `DivByZero`, `DivOn`, `DivEnd`.
- **DivFree**
  - If `start_i` = 1 and `annul_i` = 0: latch operands.
  - Divisor == 0 → go to `DivByZero`.
  - Otherwise → go to `DivOn`. Clear the 6-bit iteration counter. Load a 65-bit work register with {32'b0, |dividend|, 1'b0}. Store |divisor| as the divisor.
  - Absolute values are taken only when `signed_div_i` = 1 and the operand's bit 31 = 1: two's-complement negate.
  - Otherwise: stay in `DivFree`, `ready_o` = 0, `result_o` = 0.
- **DivByZero**: go to `DivEnd` with `result_o` = 0 and `ready_o` = 1. No trap; MIPS leaves HI/LO unpredictable, and the team defines them as 0.
- **DivOn**, while counter < 32, one step per cycle:
  - diff = {1'b0, work[63:32]} − {1'b0, divisor}, 33 bits.
  - diff[32] = 1 (borrow): work ← work << 1.
  - Otherwise: work ← {diff[31:0], work[31:0], 1'b1}.
  - Counter increments.
- **DivOn**, counter == 32:
  - quotient = work[31:0]; remainder = work[64:33].
  - If signed and dividend sign ≠ divisor sign: negate the quotient.
  - If signed and dividend negative: negate the remainder.
  - `result_o` ← {remainder, quotient}, `ready_o` ← 1, go to `DivEnd`.
- **DivEnd**
  - While `start_i` = 1: hold `result_o` and `ready_o`.
  - When `start_i` = 0: go to `DivFree` with `ready_o` ← 0 and `result_o` ← 0.
- **annul_i**
  - In `DivOn` or `DivByZero`: go to `DivFree` next edge with `ready_o` = 0. Takes priority over iteration and completion.
  - Ignored in `DivEnd`; the result was already produced.
- **Overflow**: signed 0x80000000 / −1 gives quotient 0x80000000, remainder 0. No exception.
- `start_i` toggling low while in `DivOn` has no effect. Only `annul_i` aborts.

## Timing
- Reset values: state `DivFree`, counter 0, work register 0, `result_o` 0, `ready_o` 0.
- `rst` overrides every state, including mid-operation.
- Normal latency, with `start_i` sampled at the end of cycle N:
  - Iterations occur in cycles N+1..N+32.
  - Fix-up occurs in cycle N+33.
  - `ready_o` = 1 from cycle N+34.
- Divide-by-zero latency: `ready_o` = 1 from cycle N+2.
- `ready_o` drops in the cycle after `start_i` is first seen low in `DivEnd`.
- Back-to-back operations: a new launch is possible no earlier than one cycle after `DivEnd` exits.
- EX raises its stall request combinationally from `start_i & ~ready_o`. The controller stalls IF..EX and bubbles EX/MEM. This block has no stall input: the divider keeps iterating during pipeline stalls.

## Structure
- `defines.v` gains:
  - state encodings `DivFree`/`DivByZero`/`DivOn`/`DivEnd` (2 bits);
  - `DivResultReady`/`DivResultNotReady`;
  - `DivStart`/`DivStop`;
  - `DoubleRegBus`.
- Single module. No sub-module: the subtract step and the negations are small inline combinational terms.

## Test plan
- Unsigned 100 / 7, start at N → at N+34, `ready_o` = 1, `result_o` = {32'd2, 32'd14}.
- Signed −7 / 2 → at N+34, `result_o` = {0xFFFFFFFF, 0xFFFFFFFD}.
- Signed 0x80000000 / 0xFFFFFFFF → `result_o` = {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- Divisor 0 (either mode) → at N+2, `ready_o` = 1, `result_o` = 0.
- Handshake and abort:
  - Hold `start_i` 5 cycles in `DivEnd` → result stable. Drop `start_i` → next cycle `ready_o` = 0, `result_o` = 0.
  - `annul_i` pulse at N+10 → `ready_o` never rises. A fresh 9 / 3 launch then returns {0, 3} 34 cycles later.
- Reset and stall:
  - `rst` pulse at N+20 → all outputs 0 the next cycle, state `DivFree`.
  - External stall asserted throughout an operation → same result and latency as unstalled.
